// File: rtl/mdu_hilo_pkg.sv
// +----------------------------------------------------------------------------+
// | mdu_hilo_pkg                                                               |
// | Shared encodings and constants for the HI/LO multiply/divide unit.         |
// | Contents: operation codes, FSM state encoding, iteration count,            |
// |           divide-by-zero quotient value, magnitude helper.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mdu_hilo_pkg;

  // One iteration per operand bit.
  localparam int MDU_ITER = 32;

  // Quotient reported for any divide with a zero divisor.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Two's-complement magnitude of a 32-bit value when neg is set.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_sign_fix.sv
// +----------------------------------------------------------------------------+
// | mdu_sign_fix                                                               |
// | Combinational sign correction for magnitude results.                       |
// | Multiply: whole 64-bit product negated when neg_lo is set.                 |
// | Divide:   LO (quotient) negated by neg_lo, HI (remainder) by neg_hi.       |
// | Ports: raw [63:0] in, is_div in, neg_lo in, neg_hi in, fixed [63:0] out.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mdu_sign_fix (
  input  logic [63:0] raw,
  input  logic        is_div,
  input  logic        neg_lo,
  input  logic        neg_hi,
  output logic [63:0] fixed
);

  always_comb begin
    fixed = raw;
    if (is_div) begin
      fixed[31:0]  = neg_lo ? (~raw[31:0]  + 32'd1) : raw[31:0];
      fixed[63:32] = neg_hi ? (~raw[63:32] + 32'd1) : raw[63:32];
    end else if (neg_lo) begin
      fixed = ~raw + 64'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
// +----------------------------------------------------------------------------+
// | mdu_hilo                                                                   |
// | Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO regs.    |
// | Ports: clk, rst (sync, active high), start, op[1:0], R_data_1/R_data_2     |
// |        operands, w_hi/w_lo/W_data direct writes, HI/LO results,            |
// |        busy (not IDLE), done (one-cycle result pulse).                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int ITER = MDU_ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] R_data_1,
  input  logic [31:0] R_data_2,
  input  logic        w_hi,
  input  logic        w_lo,
  input  logic [31:0] W_data,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done
);

  state_e      state, state_nx;
  logic [5:0]  cnt;
  logic        is_div, sign_a, sign_b, b_zero;
  // Multiply: opnd = |A| (addend), acc low half starts as |B| (multiplier).
  // Divide:   opnd = |B| (divisor), acc low half starts as |A| (dividend).
  logic [31:0] opnd;
  logic [63:0] acc;

  logic        in_signed, in_div;
  logic        in_sa, in_sb;
  logic [32:0] mul_sum;
  logic [32:0] div_rem, div_diff;
  logic [63:0] acc_step;
  logic [63:0] fixed;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (cnt == 6'(ITER - 1)) state_nx = ST_FIX;
      ST_FIX:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // ---------------- Operand decode ----------------
  always_comb begin
    in_signed = (op == OP_MULT) || (op == OP_DIV);
    in_div    = (op == OP_DIV)  || (op == OP_DIVU);
    in_sa     = in_signed & R_data_1[31];
    in_sb     = in_signed & R_data_2[31];
  end

  // ---------------- One iteration ----------------
  always_comb begin
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
    // Restoring divide: shift remainder:dividend left, trial-subtract the
    // divisor, keep the difference only when it did not go negative.
    div_rem  = acc[63:31];
    div_diff = div_rem - {1'b0, opnd};
    if (is_div) begin
      if (div_diff[32]) acc_step = {div_rem[31:0],  acc[30:0], 1'b0};
      else              acc_step = {div_diff[31:0], acc[30:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[31:1]};
    end
  end

  mdu_sign_fix u_sign_fix (
    .raw    (acc),
    .is_div (is_div),
    .neg_lo (sign_a ^ sign_b),
    .neg_hi (sign_a),
    .fixed  (fixed)
  );

  // ---------------- Datapath and HI/LO ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 6'd0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      opnd   <= 32'd0;
      acc    <= 64'd0;
      HI     <= 32'd0;
      LO     <= 32'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            // start takes priority; any same-cycle MTHI/MTLO is dropped.
            cnt    <= 6'd0;
            is_div <= in_div;
            sign_a <= in_sa;
            sign_b <= in_sb;
            b_zero <= in_div && (R_data_2 == 32'd0);
            if (in_div) begin
              opnd <= mag32(R_data_2, in_sb);
              acc  <= {32'd0, mag32(R_data_1, in_sa)};
            end else begin
              opnd <= mag32(R_data_1, in_sa);
              acc  <= {32'd0, mag32(R_data_2, in_sb)};
            end
          end else begin
            if (w_hi) HI <= W_data;
            if (w_lo) LO <= W_data;
          end
        end
        ST_RUN: begin
          acc <= acc_step;
          cnt <= cnt + 6'd1;
        end
        ST_FIX: begin
          // With a zero divisor the remainder path already reproduces A
          // (|A| re-signed by sA); only the quotient needs overriding.
          HI   <= fixed[63:32];
          LO   <= b_zero ? DIV0_LO : fixed[31:0];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// +----------------------------------------------------------------------------+
// | tb_mdu_hilo                                                                |
// | Self-checking bench for mdu_hilo: scoreboard of expected HI/LO pushed at   |
// | start and popped when done pulses.                                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mdu_hilo;
  import mdu_hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, w_hi, w_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wd;
  logic [31:0] HI, LO;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];

  mdu_hilo dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .R_data_1 (a),
    .R_data_2 (b),
    .w_hi     (w_hi),
    .w_lo     (w_lo),
    .W_data   (wd),
    .HI       (HI),
    .LO       (LO),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model from plain 64-bit integer arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, p, q, r;
    logic [63:0] pu;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (o)
      2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin pu = {32'd0, av} * {32'd0, bv}; eh = pu[63:32]; el = pu[31:0]; end
      2'b10: begin
        if (bv == 32'd0) begin eh = av; el = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0]; end
      end
      default: begin
        if (bv == 32'd0) begin eh = av; el = 32'hFFFF_FFFF; end
        else begin eh = av % bv; el = av / bv; end
      end
    endcase
  endtask

  // Issue one operation, wait for done, compare against the scoreboard.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input string name,
                        input bit poke_start, input bit poke_wlo, input bit wlo_at_start);
    logic [31:0] hi0, lo0, gh, gl;
    int n;
    bit held, seen;
    hi0 = HI;
    lo0 = LO;
    exp_hi_q.push_back(eh);
    exp_lo_q.push_back(el);
    op = o; a = av; b = bv; start = 1'b1;
    if (wlo_at_start) begin w_lo = 1'b1; wd = 32'hCAFE_F00D; end
    tick();  // E0
    start = 1'b0; w_lo = 1'b0;
    a = $urandom; b = $urandom;  // later operand changes must be ignored
    checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      begin errors++; $display("FAIL %s accept: busy=%b done=%b, want busy=1 done=0", name, busy, done); end
    n = 0; held = 1; seen = 0;
    while (!seen && n < 60) begin
      if (n == 10) begin
        if (poke_start) begin start = 1'b1; op = OP_MULT; end
        if (poke_wlo)   begin w_lo = 1'b1; wd = 32'hDEAD_BEEF; end
      end
      tick();
      n++;
      start = 1'b0; w_lo = 1'b0;
      if (n == 11 && (poke_start || poke_wlo)) begin
        checks++;
        if (busy !== 1'b1)
          begin errors++; $display("FAIL %s busy_after_poke: busy=%b, want 1", name, busy); end
      end
      if (done === 1'b1) seen = 1;
      else if (HI !== hi0 || LO !== lo0) held = 0;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s timeout: no done after %0d edges, want done at 33", name, n);
      return;
    end
    if (n != 33)
      begin errors++; $display("FAIL %s latency: %0d edges, want 33", name, n); end
    checks++;
    if (busy !== 1'b0)
      begin errors++; $display("FAIL %s busy_at_done: busy=%b, want 0", name, busy); end
    checks++;
    if (!held)
      begin errors++; $display("FAIL %s hold: HI/LO changed during RUN, want held at %h/%h", name, hi0, lo0); end
    checks++;
    if (exp_hi_q.size() == 0) begin
      errors++; $display("FAIL %s scoreboard: empty queue at done, want one entry", name);
    end else begin
      gh = exp_hi_q.pop_front();
      gl = exp_lo_q.pop_front();
      if (HI !== gh || LO !== gl)
        begin errors++; $display("FAIL %s result: HI=%h LO=%h, want HI=%h LO=%h", name, HI, LO, gh, gl); end
    end
  endtask

  // After done, the very next cycle must have done low again.
  task automatic check_done_low(input string name);
    tick();
    checks++;
    if (done !== 1'b0)
      begin errors++; $display("FAIL %s done_pulse: done=%b one cycle later, want 0", name, done); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; w_hi = 1'b0; w_lo = 1'b0; op = 2'b00; a = '0; b = '0; wd = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL reset: HI=%h LO=%h busy=%b done=%b, want all 0", HI, LO, busy, done); end
  endtask

  task automatic test_mult();
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult", 0, 0, 0);
    check_done_low("mult");
  endtask

  task automatic test_multu_start_ignored();
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, "multu", 1, 0, 0);
    check_done_low("multu");
  endtask

  task automatic test_div();
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7", 0, 0, 0);
    check_done_low("div_neg7");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf", 0, 0, 0);
    check_done_low("div_ovf");
  endtask

  task automatic test_div_zero();
    run_op(OP_DIVU, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF, "divu_zero", 0, 0, 0);
    check_done_low("divu_zero");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero_neg", 0, 0, 0);
    check_done_low("div_zero_neg");
  endtask

  task automatic test_mthi_mtlo();
    w_hi = 1'b1; wd = 32'h1234_5678;
    tick();
    w_hi = 1'b0;
    checks++;
    if (HI !== 32'h1234_5678)
      begin errors++; $display("FAIL mthi: HI=%h, want 12345678", HI); end
    w_hi = 1'b1; w_lo = 1'b1; wd = 32'hA5A5_0F0F;
    tick();
    w_hi = 1'b0; w_lo = 1'b0;
    checks++;
    if (HI !== 32'hA5A5_0F0F || LO !== 32'hA5A5_0F0F)
      begin errors++; $display("FAIL mthi_mtlo_both: HI=%h LO=%h, want a5a50f0f both", HI, LO); end
    // MTLO together with start is dropped; MTLO while busy is ignored.
    run_op(OP_MULTU, 32'h2, 32'h3, 32'h0, 32'h6, "start_with_mtlo", 0, 1, 1);
    check_done_low("start_with_mtlo");
  endtask

  task automatic test_reset_mid();
    int k;
    bit any_done;
    op = OP_DIVU; a = 32'hFFFF_0000; b = 32'h3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL reset_mid: HI=%h LO=%h busy=%b done=%b, want all 0", HI, LO, busy, done); end
    any_done = 0;
    for (k = 0; k < 30; k++) begin tick(); if (done === 1'b1) any_done = 1; end
    checks++;
    if (any_done)
      begin errors++; $display("FAIL reset_mid_nodone: done=1 after abort, want 0"); end
    run_op(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "multu_after_reset", 0, 0, 0);
    check_done_low("multu_after_reset");
  endtask

  // Consecutive operations, each started on the edge right after done.
  task automatic test_back_to_back();
    logic [31:0] av, bv, eh, el;
    logic [1:0]  o;
    for (int i = 0; i < 6; i++) begin
      o  = 2'(i % 4);
      av = $urandom;
      bv = (i == 5) ? 32'd0 : ((i % 2 == 0) ? $urandom : $urandom_range(1, 1000));
      model(o, av, bv, eh, el);
      run_op(o, av, bv, eh, el, $sformatf("b2b_%0d", i), 0, 0, 0);
    end
    check_done_low("b2b_last");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_start_ignored();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
